// File: rtl/fifo_fill_sched.sv
// Fill sequencer: fetches NUM_ROWS words over Avalon-MM and unpacks each into the per-row FIFO, MSB byte first.
// Optional feature: define FILL_CHECKSUM_EN to build the running byte checksum (otherwise checksum is tied to 0).
module fifo_fill_sched #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    BYTES_PER_WORD = 8,
    parameter int                    NUM_ROWS       = 9,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic [ADDR_WIDTH-1:0]                address,
    output logic                                 read,
    input  logic                                 waitrequest,
    input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] readdata,
    input  logic                                 readdatavalid,
    output logic [NUM_ROWS-1:0]                  fifo_wren,
    output logic [DATA_WIDTH-1:0]                fifo_wdata,
    input  logic [NUM_ROWS-1:0]                  fifo_full,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          checksum
);
    localparam int WORD_W = DATA_WIDTH * BYTES_PER_WORD;
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int BYTE_W = $clog2(BYTES_PER_WORD);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                        input logic [BYTE_W-1:0] k);
        pick_byte = w[(BYTES_PER_WORD - 1 - int'(k)) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic                    read_q, read_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [NUM_ROWS-1:0]     wren_q, wren_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef FILL_CHECKSUM_EN
    logic [15:0]             csum_q, csum_d;
`endif

    logic [NUM_ROWS-1:0] row_onehot;
    logic                full_row;

    assign row_onehot = NUM_ROWS'(1) << row_q;
    assign full_row   = |(fifo_full & row_onehot);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        byte_d    = byte_q;
        data_d    = data_q;
        read_d    = read_q;
        address_d = address_q;
        wren_d    = wren_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef FILL_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_REQ;
                    row_d     = '0;
                    read_d    = 1'b1;
                    address_d = BASE_ADDR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
`ifdef FILL_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            S_REQ: begin
                if (!waitrequest) begin
                    state_d = S_WAIT;
                    read_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (readdatavalid) begin
                    state_d = S_UNPACK;
                    data_d  = readdata;
                    byte_d  = '0;
                    wdata_d = pick_byte(readdata, '0);
                    wren_d  = full_row ? '0 : row_onehot;
                end
            end
            S_UNPACK: begin
                wren_d = '0;
                // wren_q high means byte_q is being pushed in the current cycle
                if (|wren_q) begin
`ifdef FILL_CHECKSUM_EN
                    csum_d = csum_q + 16'(wdata_q);
`endif
                    if (byte_q == LAST_BYTE) begin
                        if (row_q == LAST_ROW) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = S_REQ;
                            row_d     = row_q + 1'b1;
                            read_d    = 1'b1;
                            address_d = BASE_ADDR + ADDR_WIDTH'(row_q) + ADDR_WIDTH'(1);
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                        if (!full_row) begin
                            wren_d  = row_onehot;
                            wdata_d = pick_byte(data_q, byte_q + 1'b1);
                        end
                    end
                end else if (!full_row) begin
                    wren_d  = row_onehot;
                    wdata_d = pick_byte(data_q, byte_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            byte_q    <= '0;
            data_q    <= '0;
            read_q    <= 1'b0;
            address_q <= '0;
            wren_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FILL_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            read_q    <= read_d;
            address_q <= address_d;
            wren_q    <= wren_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FILL_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign fifo_wren  = wren_q;
    assign fifo_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef FILL_CHECKSUM_EN
    assign checksum   = csum_q;
`else
    assign checksum   = '0;
`endif

endmodule
